// File: rtl/pixel_pack_stream.sv
// pixel_pack_stream: packs ISIZE-bit pixels LSB-first, with no gaps, into OSIZE-bit words
// for the VDMA write path.
// Ports:
//   clock, rst_n             clock and asynchronous active-low reset
//   ivalid/iready/idata      input pixel stream (valid/ready)
//   ialign                   drop any pending residue; this pixel lands at bit 0
//   ilast                    last pixel of the line; forces out a partial final word
//   ovalid/oready/odata      output word stream (valid/ready), one register stage
//   omask                    byte enables for odata, bit k covers odata[8k+7:8k]
//   olast                    word is the final word of the line
module pixel_pack_stream #(
  parameter int ISIZE = 24,
  parameter int OSIZE = 256,
  parameter int FW    = $clog2(OSIZE + 1)
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               ivalid,
  output logic               iready,
  input  logic [ISIZE-1:0]   idata,
  input  logic               ialign,
  input  logic               ilast,
  output logic               ovalid,
  input  logic               oready,
  output logic [OSIZE-1:0]   odata,
  output logic [OSIZE/8-1:0] omask,
  output logic               olast
);

  localparam int AW = OSIZE + ISIZE;
  localparam int NW = FW + 1;  // n can reach OSIZE-1+ISIZE
  localparam int MW = OSIZE / 8;
  localparam logic [NW-1:0] ISZ = NW'(ISIZE);
  localparam logic [NW-1:0] OSZ = NW'(OSIZE);

  typedef enum logic {StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            ovalid_q, olast_q;
  logic [OSIZE-1:0] odata_q;
  logic [MW-1:0]   omask_q;

  logic            ostall, accept, load, ld_last;
  logic [FW-1:0]   base;
  logic [NW-1:0]   n;
  logic [AW-1:0]   acc_ins;
  logic [OSIZE-1:0] ld_data;
  logic [MW-1:0]   ld_mask;

  // Low ceil(nbits/8) byte-enable bits set.
  function automatic logic [MW-1:0] byte_mask(input logic [NW-1:0] nbits);
    logic [NW-1:0] nbytes;
    logic [MW-1:0] m;
    nbytes = (nbits + NW'(7)) >> 3;
    m = '0;
    for (int k = 0; k < MW; k++) m[k] = (NW'(k) < nbytes);
    return m;
  endfunction

  assign ostall  = ovalid_q & ~oready;
  assign accept  = ivalid & iready;
  assign base    = ialign ? '0 : fill_q;
  assign n       = NW'(base) + ISZ;
  // Keep only the bits below base, so ialign clears everything and nothing stale sits above n.
  assign acc_ins = (acc_q & ~({AW{1'b1}} << base)) | ({{(AW - ISIZE){1'b0}}, idata} << base);

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (accept && ilast && (n > OSZ)) state_d = StFlush;
      StFlush: if (!ostall) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // FSM outputs
  always_comb begin
    iready = (state_q == StRun) && !ostall;
  end

  // Datapath next-state and output-register load
  always_comb begin
    acc_d   = acc_q;
    fill_d  = fill_q;
    load    = 1'b0;
    ld_data = acc_ins[OSIZE-1:0];
    ld_mask = '0;
    ld_last = 1'b0;
    case (state_q)
      StRun: begin
        if (accept) begin
          if (n < OSZ) begin
            if (ilast) begin
              load    = 1'b1;
              ld_mask = byte_mask(n);
              ld_last = 1'b1;
              acc_d   = '0;
              fill_d  = '0;
            end else begin
              acc_d  = acc_ins;
              fill_d = FW'(n);
            end
          end else if (n == OSZ) begin
            load    = 1'b1;
            ld_mask = '1;
            ld_last = ilast;
            acc_d   = '0;
            fill_d  = '0;
          end else begin
            // Word boundary crossed: residue moves down, FLUSH follows if the line ends here.
            load    = 1'b1;
            ld_mask = '1;
            acc_d   = acc_ins >> OSIZE;
            fill_d  = FW'(n - OSZ);
          end
        end
      end
      StFlush: begin
        ld_data = acc_q[OSIZE-1:0];
        if (!ostall) begin
          load    = 1'b1;
          ld_mask = byte_mask(NW'(fill_q));
          ld_last = 1'b1;
          acc_d   = '0;
          fill_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      fill_q   <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      omask_q  <= '0;
      olast_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      if (load) begin
        ovalid_q <= 1'b1;
        odata_q  <= ld_data;
        omask_q  <= ld_mask;
        olast_q  <= ld_last;
      end else if (oready) begin
        ovalid_q <= 1'b0;
      end
    end
  end

  assign ovalid = ovalid_q;
  assign odata  = odata_q;
  assign omask  = omask_q;
  assign olast  = olast_q;

endmodule

// File: tb/tb_pixel_pack_stream.sv
// Bench for pixel_pack_stream: a bit-queue reference model produces the expected word stream,
// directed line scenarios plus a randomized backpressure run are checked against it.
module tb_pixel_pack_stream;

  localparam int ISIZE = 24;
  localparam int OSIZE = 256;
  localparam int MW    = OSIZE / 8;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             ivalid, iready, ialign, ilast;
  logic [ISIZE-1:0] idata;
  logic             ovalid, oready, olast;
  logic [OSIZE-1:0] odata;
  logic [MW-1:0]    omask;

  pixel_pack_stream #(
    .ISIZE(ISIZE),
    .OSIZE(OSIZE)
  ) dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .ivalid (ivalid),
    .iready (iready),
    .idata  (idata),
    .ialign (ialign),
    .ilast  (ilast),
    .ovalid (ovalid),
    .oready (oready),
    .odata  (odata),
    .omask  (omask),
    .olast  (olast)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [OSIZE-1:0] data;
    logic [MW-1:0]    mask;
    logic             last;
  } exp_t;

  bit   bitq[$];
  exp_t expq[$];

  int errors = 0;
  int checks = 0;
  int words, lasts;
  logic [MW-1:0]    last_mask;
  logic             in_acc, smp_iready, stall_q;
  logic [OSIZE-1:0] hold_data;
  logic [MW-1:0]    hold_mask;
  logic             hold_last;

  task automatic chk(input string tag, input logic [OSIZE-1:0] got, input logic [OSIZE-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: pixels become a flat bit sequence; every OSIZE bits is a word, ilast flushes
  // whatever remains as a partial word, ialign throws pending bits away.
  function automatic void model_push(input logic [ISIZE-1:0] d, input logic a, input logic l);
    exp_t e;
    int   nb;
    if (a) bitq.delete();
    for (int i = 0; i < ISIZE; i++) bitq.push_back(d[i]);
    if (bitq.size() >= OSIZE) begin
      e.data = '0;
      for (int i = 0; i < OSIZE; i++) e.data[i] = bitq.pop_front();
      e.mask = '1;
      e.last = l && (bitq.size() == 0);
      expq.push_back(e);
    end
    if (l && bitq.size() != 0) begin
      nb     = bitq.size();
      e.data = '0;
      e.mask = '0;
      for (int i = 0; i < nb; i++) e.data[i] = bitq.pop_front();
      for (int k = 0; k < (nb + 7) / 8; k++) e.mask[k] = 1'b1;
      e.last = 1'b1;
      expq.push_back(e);
    end
  endfunction

  // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    in_acc     = ivalid && iready;
    smp_iready = iready;
    if (stall_q) begin
      chk("hold_valid", OSIZE'(ovalid), OSIZE'(1'b1));
      chk("hold_data", odata, hold_data);
      chk("hold_mask", OSIZE'(omask), OSIZE'(hold_mask));
      chk("hold_last", OSIZE'(olast), OSIZE'(hold_last));
    end
    if (ovalid && oready) begin
      words++;
      last_mask = omask;
      if (olast) lasts++;
      if (expq.size() == 0) begin
        chk("unexpected_word", OSIZE'(ovalid), OSIZE'(1'b0));
      end else begin
        e = expq.pop_front();
        chk("word_data", odata, e.data);
        chk("word_mask", OSIZE'(omask), OSIZE'(e.mask));
        chk("word_last", OSIZE'(olast), OSIZE'(e.last));
      end
    end
    if (in_acc) model_push(idata, ialign, ilast);
    stall_q   = ovalid && !oready;
    hold_data = odata;
    hold_mask = omask;
    hold_last = olast;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [ISIZE-1:0] d, input logic a, input logic l, input bit rnd);
    int budget;
    if (rnd) begin
      ivalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        oready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    ivalid = 1'b1;
    idata  = d;
    ialign = a;
    ilast  = l;
    budget = 0;
    do begin
      if (rnd) oready = 1'($urandom_range(0, 1));
      tick();
      budget++;
    end while (!in_acc && budget < 100);
    if (!in_acc) chk("send_timeout", OSIZE'(in_acc), OSIZE'(1'b1));
    ivalid = 1'b0;
    ialign = 1'b0;
    ilast  = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    ivalid = 1'b0;
    oready = 1'b1;
    while ((expq.size() != 0 || ovalid) && budget < 50) begin
      tick();
      budget++;
    end
    chk("drain_empty", OSIZE'(expq.size()), OSIZE'(0));
  endtask

  task automatic clr();
    words     = 0;
    lasts     = 0;
    last_mask = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    ivalid  = 1'b0;
    idata   = '0;
    ialign  = 1'b0;
    ilast   = 1'b0;
    oready  = 1'b1;
    stall_q = 1'b0;
    clr();

    // Reset state
    #12;
    chk("rst_ovalid", OSIZE'(ovalid), OSIZE'(1'b0));
    chk("rst_odata", odata, '0);
    chk("rst_omask", OSIZE'(omask), OSIZE'(0));
    chk("rst_olast", OSIZE'(olast), OSIZE'(1'b0));
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_iready", OSIZE'(iready), OSIZE'(1'b1));

    // 32 pixels 1..32, no ilast: exactly three full words
    clr();
    for (int p = 1; p <= 32; p++) send(ISIZE'(p), 1'b0, 1'b0, 1'b0);
    drain();
    chk("t1_words", OSIZE'(words), OSIZE'(3));
    chk("t1_lasts", OSIZE'(lasts), OSIZE'(0));

    // 11-pixel line: full word, FLUSH bubble, 1-byte final word
    clr();
    for (int p = 1; p <= 11; p++) send(ISIZE'(p), 1'b0, p == 11, 1'b0);
    tick();
    chk("t2_flush_iready", OSIZE'(smp_iready), OSIZE'(1'b0));
    drain();
    chk("t2_words", OSIZE'(words), OSIZE'(2));
    chk("t2_mask", OSIZE'(last_mask), OSIZE'(32'h0000_0001));
    chk("t2_lasts", OSIZE'(lasts), OSIZE'(1));

    // 5-pixel line: one partial word of 120 bits
    clr();
    for (int p = 1; p <= 5; p++) send(ISIZE'($urandom), 1'b0, p == 5, 1'b0);
    drain();
    chk("t3_words", OSIZE'(words), OSIZE'(1));
    chk("t3_mask", OSIZE'(last_mask), OSIZE'(32'h0000_7FFF));

    // ialign after 3 pixels drops 72 bits; line of 2 aligned pixels follows
    clr();
    for (int p = 1; p <= 3; p++) send(ISIZE'($urandom), 1'b0, 1'b0, 1'b0);
    send(24'hA5A5A5, 1'b1, 1'b0, 1'b0);
    send(24'h123456, 1'b0, 1'b1, 1'b0);
    drain();
    chk("t4_words", OSIZE'(words), OSIZE'(1));
    chk("t4_mask", OSIZE'(last_mask), OSIZE'(32'h0000_003F));

    // ialign + ilast on one pixel: single-pixel line
    clr();
    send(ISIZE'($urandom), 1'b0, 1'b0, 1'b0);
    send(24'hC0FFEE, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t5_words", OSIZE'(words), OSIZE'(1));
    chk("t5_mask", OSIZE'(last_mask), OSIZE'(32'h0000_0007));

    // Random ivalid/oready, 28 lines of 37 pixels, occasional ialign
    clr();
    for (int line = 0; line < 28; line++) begin
      for (int p = 0; p < 37; p++) begin
        send(ISIZE'($urandom), 1'($urandom_range(0, 15) == 0), p == 36, 1'b1);
      end
    end
    drain();
    chk("rand_lasts", OSIZE'(lasts), OSIZE'(28));

    // Reset while sitting in FLUSH with a stalled word
    clr();
    oready = 1'b0;
    for (int p = 1; p <= 11; p++) send(ISIZE'(p), 1'b0, p == 11, 1'b0);
    tick();
    chk("pre_rst_ovalid", OSIZE'(ovalid), OSIZE'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("async_ovalid", OSIZE'(ovalid), OSIZE'(1'b0));
    chk("async_odata", odata, '0);
    chk("async_omask", OSIZE'(omask), OSIZE'(0));
    chk("async_olast", OSIZE'(olast), OSIZE'(1'b0));
    bitq.delete();
    expq.delete();
    stall_q = 1'b0;
    @(negedge clock);
    rst_n  = 1'b1;
    oready = 1'b1;
    @(posedge clock);
    #1;
    clr();
    for (int p = 1; p <= 10; p++) send(ISIZE'($urandom), 1'b0, p == 10, 1'b0);
    drain();
    chk("t6_words", OSIZE'(words), OSIZE'(1));
    chk("t6_mask", OSIZE'(last_mask), OSIZE'(32'h3FFF_FFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
